// File: rtl/cp0_irq_ctrl_pkg.sv
// cp0_irq_ctrl_pkg
//   Shared constants for the CP0 interrupt controller:
//   - register addresses (CP0_REG_*, including CP0_REG_BADVADDR)
//   - exception codes as delivered by the exception unit
//   - Status/Cause bit positions
//   - reset values of the architectural registers
//   - a helper that classifies an exception code
package cp0_irq_ctrl_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam int STATUS_IE_BIT   = 0;
    localparam int STATUS_EXL_BIT  = 1;
    localparam int STATUS_IM_LSB   = 8;
    localparam int CAUSE_EXC_LSB   = 2;
    localparam int CAUSE_IP_LSB    = 8;
    localparam int CAUSE_HW_LSB    = 10;
    localparam int CAUSE_TIMER_BIT = 15;
    localparam int CAUSE_BD_BIT    = 31;

    localparam logic [31:0] COUNT_RESET    = 32'h0000_0000;
    localparam logic [31:0] COMPARE_RESET  = 32'h0000_0000;
    localparam logic [31:0] STATUS_RESET   = 32'h1000_0000;
    localparam logic [31:0] CAUSE_RESET    = 32'h0000_0000;
    localparam logic [31:0] EPC_RESET      = 32'h0000_0000;
    localparam logic [31:0] BADVADDR_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        EXC_KIND_NONE,
        EXC_KIND_ENTRY,
        EXC_KIND_ERET
    } exc_kind_e;

    // Any code outside the known set is "no exception this cycle".
    function automatic exc_kind_e decode_exc(input logic [31:0] code);
        exc_kind_e kind;
        case (code)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYSCALL,
            EXC_RI, EXC_OV, EXC_TRAP: kind = EXC_KIND_ENTRY;
            EXC_ERET:                 kind = EXC_KIND_ERET;
            default:                  kind = EXC_KIND_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// cp0_irq_ctrl_if
//   Bundles the pipeline-facing signals of the CP0 interrupt controller.
//   slave  : the controller side (cp0_irq_ctrl)
//   master : the pipeline / exception-unit side
//   Signals: CP0 move write (we/waddr/wsel/data_i), combinational read
//   (raddr/rsel/data_o), exception inputs, hardware interrupts, register
//   outputs, timer flags and the masked interrupt request.
//   bad_addr_i exists only when CP0_BADVADDR_EN is defined.
interface cp0_irq_ctrl_if #(
    parameter int DW       = 32,
    parameter int N_HW_INT = 6,
    parameter int N_TIMER  = 2
);
    logic                we_i;
    logic [4:0]          waddr_i;
    logic [2:0]          wsel_i;
    logic [4:0]          raddr_i;
    logic [2:0]          rsel_i;
    logic [DW-1:0]       data_i;
    logic [DW-1:0]       data_o;
    logic [31:0]         excepttype_i;
    logic [N_HW_INT-1:0] int_i;
    logic [DW-1:0]       current_inst_addr_i;
    logic                is_in_delayslot_i;
`ifdef CP0_BADVADDR_EN
    logic [DW-1:0]       bad_addr_i;
`endif
    logic [DW-1:0]       count_o;
    logic [DW-1:0]       status_o;
    logic [DW-1:0]       cause_o;
    logic [DW-1:0]       epc_o;
    logic [N_TIMER-1:0]  timer_int_o;
    logic                int_req_o;

`ifdef CP0_BADVADDR_EN
    modport slave (
        input  we_i, waddr_i, wsel_i, raddr_i, rsel_i, data_i,
        input  excepttype_i, int_i, current_inst_addr_i, is_in_delayslot_i,
        input  bad_addr_i,
        output data_o, count_o, status_o, cause_o, epc_o, timer_int_o, int_req_o
    );
    modport master (
        output we_i, waddr_i, wsel_i, raddr_i, rsel_i, data_i,
        output excepttype_i, int_i, current_inst_addr_i, is_in_delayslot_i,
        output bad_addr_i,
        input  data_o, count_o, status_o, cause_o, epc_o, timer_int_o, int_req_o
    );
`else
    modport slave (
        input  we_i, waddr_i, wsel_i, raddr_i, rsel_i, data_i,
        input  excepttype_i, int_i, current_inst_addr_i, is_in_delayslot_i,
        output data_o, count_o, status_o, cause_o, epc_o, timer_int_o, int_req_o
    );
    modport master (
        output we_i, waddr_i, wsel_i, raddr_i, rsel_i, data_i,
        output excepttype_i, int_i, current_inst_addr_i, is_in_delayslot_i,
        input  data_o, count_o, status_o, cause_o, epc_o, timer_int_o, int_req_o
    );
`endif

endinterface

// File: rtl/cp0_irq_ctrl_timer_ch.sv
// cp0_timer_ch
//   One compare/timer channel: a Compare register and its sticky flag.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     we       : write strobe for this channel's Compare register
//     wdata    : write data
//     count    : current Count register value
//     compare  : Compare register value
//     flag     : sticky match flag
//   A compare value of 0 disables matching. Writing Compare clears the flag,
//   and that clear beats a match arriving on the same edge.
module cp0_timer_ch
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] count,
    output logic [DW-1:0] compare,
    output logic          flag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= COMPARE_RESET[DW-1:0];
            flag    <= 1'b0;
        end else if (we) begin
            compare <= wdata;
            flag    <= 1'b0;
        end else if ((compare != '0) && (count == compare)) begin
            flag    <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl
//   Coprocessor-0 with N_TIMER compare/timer channels, N_HW_INT hardware
//   interrupt lines, masked interrupt request and exception entry/return.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : cp0_irq_ctrl_if.slave (CP0 moves, read port, exception
//                inputs, interrupt lines, register outputs, int_req_o)
//   Optional feature: define CP0_BADVADDR_EN to add the bad_addr_i input and
//   the read-only BadVAddr register (reg 8, sel 0) loaded on AdEL/AdES.
//   The write port is a single-cycle strobe: we_i is sampled on every rising
//   edge and there is no backpressure; a write always completes on that edge.
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int          DW         = 32,
    parameter int          N_HW_INT   = 6,
    parameter int          N_TIMER    = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input logic           clk,
    input logic           rst,
    cp0_irq_ctrl_if.slave bus
);

    logic [DW-1:0]      count_q, count_d;
    logic [DW-1:0]      status_q, status_d;
    logic [DW-1:0]      cause_q, cause_d;
    logic [DW-1:0]      epc_q, epc_d;
    logic [DW-1:0]      compare_q [N_TIMER];
    logic [N_TIMER-1:0] timer_flag;
    logic [DW-1:0]      rdata;
    logic [7:0]         ip_masked;
    exc_kind_e          exc_kind;
    logic               exl_q;
    logic               wr_sel0;
    logic               wr_count, wr_status, wr_cause, wr_epc;

    assign exc_kind  = decode_exc(bus.excepttype_i);
    assign exl_q     = status_q[STATUS_EXL_BIT];
    assign wr_sel0   = bus.we_i && (bus.wsel_i == 3'd0);
    assign wr_count  = wr_sel0 && (bus.waddr_i == CP0_REG_COUNT);
    assign wr_status = wr_sel0 && (bus.waddr_i == CP0_REG_STATUS);
    assign wr_cause  = wr_sel0 && (bus.waddr_i == CP0_REG_CAUSE);
    assign wr_epc    = wr_sel0 && (bus.waddr_i == CP0_REG_EPC);

    // Timer channels: Compare sel k belongs to channel k.
    for (genvar k = 0; k < N_TIMER; k++) begin : g_timer
        logic cmp_we;
        assign cmp_we = bus.we_i && (bus.waddr_i == CP0_REG_COMPARE) &&
                        (bus.wsel_i == 3'(k));
        cp0_timer_ch #(.DW(DW)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .we      (cmp_we),
            .wdata   (bus.data_i),
            .count   (count_q),
            .compare (compare_q[k]),
            .flag    (timer_flag[k])
        );
    end

    // Next-state for the architectural registers. Software write first,
    // then exception effects override only the fields they touch.
    always_comb begin
        count_d  = wr_count ? bus.data_i : count_q + 1'b1;

        status_d = status_q;
        if (wr_status) status_d = bus.data_i;
        if (exc_kind == EXC_KIND_ENTRY) status_d[STATUS_EXL_BIT] = 1'b1;
        if (exc_kind == EXC_KIND_ERET)  status_d[STATUS_EXL_BIT] = 1'b0;

        cause_d = cause_q;
        if (wr_cause) begin
            cause_d[9:8]   = bus.data_i[9:8];
            cause_d[23:22] = bus.data_i[23:22];
        end
        cause_d[CAUSE_HW_LSB +: N_HW_INT] = bus.int_i;
        // Timer interrupt shares IP7 with the top hardware line.
        cause_d[CAUSE_TIMER_BIT] = (|timer_flag) |
                                   ((N_HW_INT == 6) && bus.int_i[N_HW_INT-1]);
        if (exc_kind == EXC_KIND_ENTRY) begin
            cause_d[CAUSE_EXC_LSB +: 5] = bus.excepttype_i[4:0];
            if (!exl_q) cause_d[CAUSE_BD_BIT] = bus.is_in_delayslot_i;
        end

        epc_d = epc_q;
        if (wr_epc) epc_d = bus.data_i;
        // Nested exceptions keep the original return address.
        if ((exc_kind == EXC_KIND_ENTRY) && !exl_q) begin
            epc_d = bus.is_in_delayslot_i ? bus.current_inst_addr_i - DW'(4)
                                          : bus.current_inst_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= COUNT_RESET[DW-1:0];
            status_q <= STATUS_RESET[DW-1:0];
            cause_q  <= CAUSE_RESET[DW-1:0];
            epc_q    <= EPC_RESET[DW-1:0];
        end else begin
            count_q  <= count_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [DW-1:0] badvaddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= BADVADDR_RESET[DW-1:0];
        end else if ((bus.excepttype_i == EXC_ADEL) ||
                     (bus.excepttype_i == EXC_ADES)) begin
            badvaddr_q <= bus.bad_addr_i;
        end
    end
`endif

    // Combinational read port; unmapped register/select pairs read 0.
    always_comb begin
        rdata = '0;
        if (!rst) begin
            if (bus.rsel_i == 3'd0) begin
                case (bus.raddr_i)
                    CP0_REG_COUNT:    rdata = count_q;
                    CP0_REG_STATUS:   rdata = status_q;
                    CP0_REG_CAUSE:    rdata = cause_q;
                    CP0_REG_EPC:      rdata = epc_q;
                    CP0_REG_PRID:     rdata = PRID_VAL[DW-1:0];
                    CP0_REG_CONFIG:   rdata = CONFIG_VAL[DW-1:0];
`ifdef CP0_BADVADDR_EN
                    CP0_REG_BADVADDR: rdata = badvaddr_q;
`endif
                    default:          rdata = '0;
                endcase
            end
            if (bus.raddr_i == CP0_REG_COMPARE) begin
                for (int k = 0; k < N_TIMER; k++) begin
                    if (bus.rsel_i == 3'(k)) rdata = compare_q[k];
                end
            end
        end
    end

    assign ip_masked = cause_q[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8];

    assign bus.data_o      = rdata;
    assign bus.count_o     = count_q;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_q;
    assign bus.epc_o       = epc_q;
    assign bus.timer_int_o = timer_flag;
    assign bus.int_req_o   = !rst && (|ip_masked) && status_q[STATUS_IE_BIT] &&
                             !exl_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb_cp0_irq_ctrl
//   Bench for cp0_irq_ctrl: a register-level model advanced on each rising
//   edge, a negedge compare process against that model, and directed
//   sequences with hand-computed literal expectations.
module tb_cp0_irq_ctrl;

    localparam int DW       = 32;
    localparam int N_HW_INT = 6;
    localparam int N_TIMER  = 2;
    localparam logic [31:0] PRID   = 32'h004C0102;
    localparam logic [31:0] CONFIG = 32'h00008000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic found;

    cp0_irq_ctrl_if #(.DW(DW), .N_HW_INT(N_HW_INT), .N_TIMER(N_TIMER)) bus ();

    cp0_irq_ctrl #(
        .DW(DW), .N_HW_INT(N_HW_INT), .N_TIMER(N_TIMER),
        .PRID_VAL(PRID), .CONFIG_VAL(CONFIG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]        m_count, m_status, m_cause, m_epc, m_bad;
    logic [31:0]        m_cmp [N_TIMER];
    logic [N_TIMER-1:0] m_flag;
    logic               m_valid = 1'b0;

    function automatic logic [31:0] model_read(input logic [4:0] a,
                                               input logic [2:0] s);
        if (a == 5'd11) return (int'(s) < N_TIMER) ? m_cmp[s[0]] : 32'd0;
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd9:  return m_count;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
            5'd16: return CONFIG;
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_bad;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_int_req();
        logic [7:0] pend;
        pend = m_cause[15:8] & m_status[15:8];
        return (pend != 8'd0) && m_status[0] && !m_status[1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_count  = 0; m_status = 32'h10000000; m_cause = 0;
            m_epc    = 0; m_bad = 0; m_flag = '0;
            for (int k = 0; k < N_TIMER; k++) m_cmp[k] = 0;
            m_valid  = 1'b1;
        end else begin
            logic entry, eret, old_exl, old_any;
            logic [31:0] code;
            code    = bus.excepttype_i;
            entry   = code inside {32'h1, 32'h4, 32'h5, 32'h8, 32'ha, 32'hc, 32'hd};
            eret    = (code == 32'he);
            old_exl = m_status[1];
            old_any = |m_flag;

            for (int k = 0; k < N_TIMER; k++) begin
                if (bus.we_i && bus.waddr_i == 5'd11 && int'(bus.wsel_i) == k) begin
                    m_cmp[k]  = bus.data_i;
                    m_flag[k] = 1'b0;
                end else if (m_cmp[k] != 0 && m_count == m_cmp[k]) begin
                    m_flag[k] = 1'b1;
                end
            end

            if (bus.we_i && bus.wsel_i == 0 && bus.waddr_i == 5'd12) m_status = bus.data_i;
            if (entry) m_status[1] = 1'b1;
            if (eret)  m_status[1] = 1'b0;

            if (bus.we_i && bus.wsel_i == 0 && bus.waddr_i == 5'd13) begin
                m_cause[9:8]   = bus.data_i[9:8];
                m_cause[23:22] = bus.data_i[23:22];
            end
            m_cause[14:10] = bus.int_i[4:0];
            m_cause[15]    = bus.int_i[5] | old_any;
            if (entry) begin
                m_cause[6:2] = code[4:0];
                if (!old_exl) m_cause[31] = bus.is_in_delayslot_i;
            end

            if (bus.we_i && bus.wsel_i == 0 && bus.waddr_i == 5'd14) m_epc = bus.data_i;
            if (entry && !old_exl)
                m_epc = bus.current_inst_addr_i - (bus.is_in_delayslot_i ? 32'd4 : 32'd0);

`ifdef CP0_BADVADDR_EN
            if (code == 32'h4 || code == 32'h5) m_bad = bus.bad_addr_i;
`endif

            if (bus.we_i && bus.wsel_i == 0 && bus.waddr_i == 5'd9) m_count = bus.data_i;
            else m_count = m_count + 32'd1;
        end
    end

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("count_o",   bus.count_o,  m_count);
            chk("status_o",  bus.status_o, m_status);
            chk("cause_o",   bus.cause_o,  m_cause);
            chk("epc_o",     bus.epc_o,    m_epc);
            chk("timer_int", {30'd0, bus.timer_int_o}, {30'd0, m_flag});
            chk("int_req",   {31'd0, bus.int_req_o},
                {31'd0, (rst ? 1'b0 : model_int_req())});
            chk("data_o",    bus.data_o,
                rst ? 32'd0 : model_read(bus.raddr_i, bus.rsel_i));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic cp0_write(input logic [4:0] a, input logic [2:0] s,
                             input logic [31:0] d);
        cycle();
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wsel_i = s; bus.data_i = d;
        cycle();
        bus.we_i = 1'b0;
    endtask

    task automatic raise_exc(input logic [31:0] code, input logic [31:0] pc,
                             input logic ds);
        cycle();
        bus.excepttype_i = code; bus.current_inst_addr_i = pc;
        bus.is_in_delayslot_i = ds;
        cycle();
        bus.excepttype_i = 32'd0; bus.is_in_delayslot_i = 1'b0;
    endtask

    task automatic write_with_exc(input logic [4:0] a, input logic [31:0] d,
                                  input logic [31:0] code);
        cycle();
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wsel_i = 3'd0; bus.data_i = d;
        bus.excepttype_i = code; bus.current_inst_addr_i = 32'h300;
        cycle();
        bus.we_i = 1'b0; bus.excepttype_i = 32'd0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [2:0] s);
        cycle();
        bus.raddr_i = a; bus.rsel_i = s;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        checks = 0; failures = 0; found = 1'b0;
        rst = 1'b1;
        bus.we_i = 0; bus.waddr_i = 0; bus.wsel_i = 0; bus.data_i = 0;
        bus.raddr_i = 5'd15; bus.rsel_i = 0; bus.excepttype_i = 0;
        bus.int_i = '0; bus.current_inst_addr_i = 0; bus.is_in_delayslot_i = 0;
`ifdef CP0_BADVADDR_EN
        bus.bad_addr_i = 0;
`endif

        // Reset held for three edges, then count runs 0,1,2.
        cycle();
        at_neg();
        chk("rst_data_o", bus.data_o, 32'd0);
        chk("rst_status", bus.status_o, 32'h10000000);
        cycle(); cycle();
        rst = 1'b0;
        at_neg();
        chk("count_0", bus.count_o, 32'd0);
        chk("prid",    bus.data_o, 32'h004C0102);
        cycle(); at_neg(); chk("count_1", bus.count_o, 32'd1);
        cycle(); at_neg(); chk("count_2", bus.count_o, 32'd2);
        rd(5'd16, 3'd0); at_neg(); chk("config", bus.data_o, 32'h00008000);

        // Timer channel 1 with IM7 and IE enabled.
        cp0_write(5'd12, 3'd0, 32'h00008001);
        cp0_write(5'd11, 3'd1, 32'd20);
        rd(5'd11, 3'd1); at_neg(); chk("cmp1_read", bus.data_o, 32'd20);
        rd(5'd11, 3'd3); at_neg(); chk("cmp3_read", bus.data_o, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            at_neg();
            if (bus.count_o == 32'd20) begin found = 1'b1; break; end
        end
        chk("timer_reach_20", {31'd0, found}, 32'd1);
        chk("timer_before", {30'd0, bus.timer_int_o}, 32'd0);
        at_neg();
        chk("timer_set", {30'd0, bus.timer_int_o}, 32'd2);
        chk("int_req_lag", {31'd0, bus.int_req_o}, 32'd0);
        at_neg();
        chk("int_req_timer", {31'd0, bus.int_req_o}, 32'd1);
        at_neg(); at_neg(); at_neg();
        chk("timer_sticky", {30'd0, bus.timer_int_o}, 32'd2);
        cp0_write(5'd11, 3'd1, 32'd0);
        at_neg();
        chk("timer_clear", {30'd0, bus.timer_int_o}, 32'd0);

        // Count write and wrap.
        cp0_write(5'd9, 3'd0, 32'hFFFFFFFE);
        at_neg(); chk("count_wr",   bus.count_o, 32'hFFFFFFFE);
        at_neg(); chk("count_max",  bus.count_o, 32'hFFFFFFFF);
        at_neg(); chk("count_wrap", bus.count_o, 32'd0);

        // Syscall in a delay slot, nested syscall, eret.
        raise_exc(32'h8, 32'h100, 1'b1);
        at_neg();
        chk("sys_epc",  bus.epc_o, 32'h000000FC);
        chk("sys_bd",   {31'd0, bus.cause_o[31]}, 32'd1);
        chk("sys_code", {27'd0, bus.cause_o[6:2]}, 32'd8);
        chk("sys_exl",  {31'd0, bus.status_o[1]}, 32'd1);
        raise_exc(32'h8, 32'h200, 1'b0);
        at_neg();
        chk("nest_epc", bus.epc_o, 32'h000000FC);
        chk("nest_bd",  {31'd0, bus.cause_o[31]}, 32'd1);
        raise_exc(32'he, 32'h0, 1'b0);
        at_neg();
        chk("eret_exl", {31'd0, bus.status_o[1]}, 32'd0);

        // Status write in the same cycle as an overflow exception.
        write_with_exc(5'd12, 32'h0000FF01, 32'hc);
        at_neg();
        chk("same_status", bus.status_o, 32'h0000FF03);
        chk("same_code",   {27'd0, bus.cause_o[6:2]}, 32'd12);
        chk("same_epc",    bus.epc_o, 32'h00000300);
        raise_exc(32'he, 32'h0, 1'b0);

        // Masking of hardware line 2 (IP4).
        cp0_write(5'd12, 3'd0, 32'h00000001);
        bus.int_i = 6'b000100;
        cycle();
        at_neg();
        chk("mask_ip",    {24'd0, bus.cause_o[15:8]}, 32'h10);
        chk("mask_off",   {31'd0, bus.int_req_o}, 32'd0);
        cp0_write(5'd12, 3'd0, 32'h00001001);
        at_neg();
        chk("mask_on",    {31'd0, bus.int_req_o}, 32'd1);
        cp0_write(5'd12, 3'd0, 32'h00001003);
        at_neg();
        chk("mask_exl",   {31'd0, bus.int_req_o}, 32'd0);
        cycle();
        bus.int_i = '0;
        raise_exc(32'he, 32'h0, 1'b0);

        // Software-writable Cause bits only.
        cp0_write(5'd13, 3'd0, 32'hFFFFFFFF);
        at_neg();
        chk("cause_sw", bus.cause_o & 32'h00C0FF00, 32'h00C00300);

        // BadVAddr.
`ifdef CP0_BADVADDR_EN
        cycle();
        bus.bad_addr_i = 32'hDEADBEE1;
        raise_exc(32'h4, 32'h400, 1'b0);
        rd(5'd8, 3'd0); at_neg();
        chk("badvaddr",      bus.data_o, 32'hDEADBEE1);
        chk("badvaddr_code", {27'd0, bus.cause_o[6:2]}, 32'd4);
        cp0_write(5'd8, 3'd0, 32'd0);
        at_neg();
        chk("badvaddr_ro",   bus.data_o, 32'hDEADBEE1);
`else
        raise_exc(32'h4, 32'h400, 1'b0);
        rd(5'd8, 3'd0); at_neg();
        chk("reg8_zero",  bus.data_o, 32'd0);
        chk("adel_code",  {27'd0, bus.cause_o[6:2]}, 32'd4);
        chk("adel_epc",   bus.epc_o, 32'h00000400);
`endif
        raise_exc(32'he, 32'h0, 1'b0);

        // Unmapped accesses.
        cp0_write(5'd20, 3'd0, 32'h12345678);
        rd(5'd20, 3'd0); at_neg(); chk("unmapped_rd", bus.data_o, 32'd0);
        rd(5'd12, 3'd1); at_neg(); chk("bad_sel_rd",  bus.data_o, 32'd0);

        // Pending timer flag lost on a mid-run reset.
        cp0_write(5'd9, 3'd0, 32'd3);
        cp0_write(5'd11, 3'd0, 32'd5);
        rd(5'd15, 3'd0);
        at_neg();
        chk("ch0_pending", {30'd0, bus.timer_int_o}, 32'd1);
        cycle();
        rst = 1'b1;
        at_neg();
        chk("mid_rst_data", bus.data_o, 32'd0);
        chk("mid_rst_req",  {31'd0, bus.int_req_o}, 32'd0);
        cycle();
        at_neg();
        chk("mid_rst_timer",  {30'd0, bus.timer_int_o}, 32'd0);
        chk("mid_rst_status", bus.status_o, 32'h10000000);
        chk("mid_rst_count",  bus.count_o, 32'd0);
        chk("mid_rst_epc",    bus.epc_o, 32'd0);
        cycle();
        rst = 1'b0;
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
